// File: rtl/mirfak_if_stage_pkg.sv
// Shared constants for the Mirfak instruction fetch stage.
//   NOP                     - canonical addi x0,x0,0 used for bubbles
//   E_INST_ADDR_MISALIGNED  - cause code, instruction address misaligned
//   E_INST_ACCESS_FAULT     - cause code, instruction access fault
//   RESET_ADDR_DEFAULT      - default PC after reset
//   word_align()            - clears the byte-offset bits of an address
package mirfak_if_stage_pkg;

  localparam logic [31:0] NOP                    = 32'h0000_0013;
  localparam logic [3:0]  E_INST_ADDR_MISALIGNED = 4'd0;
  localparam logic [3:0]  E_INST_ACCESS_FAULT    = 4'd1;
  localparam logic [31:0] RESET_ADDR_DEFAULT     = 32'h8000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mirfak_if_stage.sv
// Instruction fetch stage plus IF/ID pipeline register.
// Fetches over a Wishbone classic port, applies ID and trap redirects,
// and hands {pc, pc4, instruction, exception, xcause, bubble} to ID.
//
// Ports
//   clk_i, rstn_i          clock, synchronous active-low reset
//   iwbm_*                 Wishbone classic instruction master
//   take_branch_i/target   redirect from ID
//   xcall_i/target         redirect from trap/mret (wins over ID)
//   ifid_enable_i/clear_i  hazard-unit control of the IF/ID register
//   if_busy_o              no instruction available for ID this cycle
//   id_*                   IF/ID register outputs
//
// state   | meaning
// FETCH   | bus request active, waiting for ack/err
// HOLD    | word (or fault) buffered, waiting for IF/ID enable
// DISCARD | redirected mid-transfer, finishing the stale request
// FAULT   | fetch error reported, only a trap redirect leaves
module mirfak_if_stage
  import mirfak_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic [31:0] iwbm_addr_o,
  output logic        iwbm_cyc_o,
  output logic        iwbm_stb_o,
  input  logic [31:0] iwbm_dat_i,
  input  logic        iwbm_ack_i,
  input  logic        iwbm_err_i,
  input  logic        take_branch_i,
  input  logic [31:0] pc_bj_target_i,
  input  logic        xcall_i,
  input  logic [31:0] xcall_target_i,
  input  logic        ifid_enable_i,
  input  logic        ifid_clear_i,
  output logic        if_busy_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic [31:0] id_instruction_o,
  output logic        id_if_exception_o,
  output logic [3:0]  id_if_xcause_o,
  output logic        id_bubble_o
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD, S_FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc4;
  // Redirect target parked while a stale transfer drains; the bus address
  // must not move until that transfer completes.
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        buf_fault_q, buf_fault_d;
  // Low during reset and the first cycle after it so no request is raised early.
  logic        run_q;

  logic        redirect, done;
  logic [31:0] target;
  logic        ld_valid, ld_exc;
  logic [31:0] ld_inst;

  assign pc4      = pc_q + 32'd4;
  assign redirect = xcall_i || take_branch_i;
  assign target   = word_align(xcall_i ? xcall_target_i : pc_bj_target_i);
  assign done     = iwbm_ack_i || iwbm_err_i;

  assign iwbm_addr_o = word_align(pc_q);
  assign iwbm_cyc_o  = run_q && (state_q == S_FETCH || state_q == S_DISCARD);
  assign iwbm_stb_o  = iwbm_cyc_o;
  assign if_busy_o   = !(state_q == S_HOLD || (run_q && state_q == S_FETCH && done));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    buf_inst_d  = buf_inst_q;
    buf_fault_d = buf_fault_q;
    ld_valid    = 1'b0;
    ld_exc      = 1'b0;
    ld_inst     = NOP;
    unique case (state_q)
      S_FETCH: begin
        if (run_q) begin
          if (redirect) begin
            if (done) begin
              pc_d = target;
            end else begin
              tgt_d   = target;
              state_d = S_DISCARD;
            end
          end else if (iwbm_ack_i) begin
            if (ifid_enable_i) begin
              ld_valid = 1'b1;
              ld_inst  = iwbm_dat_i;
              pc_d     = pc4;
            end else begin
              buf_inst_d  = iwbm_dat_i;
              buf_fault_d = 1'b0;
              state_d     = S_HOLD;
            end
          end else if (iwbm_err_i) begin
            if (ifid_enable_i) begin
              ld_valid = 1'b1;
              ld_exc   = 1'b1;
              state_d  = S_FAULT;
            end else begin
              buf_inst_d  = NOP;
              buf_fault_d = 1'b1;
              state_d     = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_FETCH;
        end else if (ifid_enable_i) begin
          ld_valid = 1'b1;
          ld_inst  = buf_inst_q;
          ld_exc   = buf_fault_q;
          if (buf_fault_q) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = pc4;
            state_d = S_FETCH;
          end
        end
      end
      S_DISCARD: begin
        // A later redirect replaces the parked target.
        if (redirect) tgt_d = target;
        if (done) begin
          pc_d    = redirect ? target : tgt_q;
          state_d = S_FETCH;
        end
      end
      S_FAULT: begin
        if (xcall_i) begin
          pc_d    = word_align(xcall_target_i);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_ADDR;
      tgt_q       <= RESET_ADDR;
      buf_inst_q  <= NOP;
      buf_fault_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      buf_inst_q  <= buf_inst_d;
      buf_fault_q <= buf_fault_d;
      run_q       <= 1'b1;
    end

    if (!rstn_i || ifid_clear_i || (ifid_enable_i && !ld_valid)) begin
      id_pc_o           <= 32'd0;
      id_pc4_o          <= 32'd0;
      id_instruction_o  <= NOP;
      id_if_exception_o <= 1'b0;
      id_if_xcause_o    <= 4'd0;
      id_bubble_o       <= 1'b1;
    end else if (ifid_enable_i) begin
      id_pc_o           <= pc_q;
      id_pc4_o          <= pc4;
      id_instruction_o  <= ld_inst;
      id_if_exception_o <= ld_exc;
      id_if_xcause_o    <= ld_exc ? E_INST_ACCESS_FAULT : 4'd0;
      id_bubble_o       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mirfak_if_stage.sv
module tb_mirfak_if_stage;
  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] iwbm_addr_o;
  logic        iwbm_cyc_o, iwbm_stb_o;
  logic [31:0] iwbm_dat_i;
  logic        iwbm_ack_i, iwbm_err_i;
  logic        take_branch_i, xcall_i;
  logic [31:0] pc_bj_target_i, xcall_target_i;
  logic        ifid_enable_i, ifid_clear_i;
  logic        if_busy_o;
  logic [31:0] id_pc_o, id_pc4_o, id_instruction_o;
  logic        id_if_exception_o;
  logic [3:0]  id_if_xcause_o;
  logic        id_bubble_o;

  // Slave model: zero-wait when ack_req is set; data defaults to addr+0x1000.
  logic        ack_req, err_req, dat_ovr;
  logic [31:0] dat_val;
  int          total = 0;
  int          bad   = 0;

  assign iwbm_ack_i = iwbm_cyc_o && ack_req;
  assign iwbm_err_i = iwbm_cyc_o && err_req;
  assign iwbm_dat_i = dat_ovr ? dat_val : iwbm_addr_o + 32'h0000_1000;

  always #5 clk_i = ~clk_i;

  mirfak_if_stage dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .iwbm_addr_o(iwbm_addr_o), .iwbm_cyc_o(iwbm_cyc_o), .iwbm_stb_o(iwbm_stb_o),
    .iwbm_dat_i(iwbm_dat_i), .iwbm_ack_i(iwbm_ack_i), .iwbm_err_i(iwbm_err_i),
    .take_branch_i(take_branch_i), .pc_bj_target_i(pc_bj_target_i),
    .xcall_i(xcall_i), .xcall_target_i(xcall_target_i),
    .ifid_enable_i(ifid_enable_i), .ifid_clear_i(ifid_clear_i),
    .if_busy_o(if_busy_o),
    .id_pc_o(id_pc_o), .id_pc4_o(id_pc4_o), .id_instruction_o(id_instruction_o),
    .id_if_exception_o(id_if_exception_o), .id_if_xcause_o(id_if_xcause_o),
    .id_bubble_o(id_bubble_o)
  );

  always @(negedge clk_i) begin
    assert (!(iwbm_ack_i && iwbm_err_i)) else begin
      bad++;
      $error("FAIL ack_err observed=1 expected=0");
    end
    assert (iwbm_cyc_o === iwbm_stb_o) else begin
      bad++;
      $error("FAIL cyc_stb observed=%b expected=%b", iwbm_stb_o, iwbm_cyc_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rstn_i = 1'b0; take_branch_i = 1'b0; xcall_i = 1'b0;
    pc_bj_target_i = 32'd0; xcall_target_i = 32'd0;
    ifid_enable_i = 1'b1; ifid_clear_i = 1'b0;
    ack_req = 1'b1; err_req = 1'b0; dat_ovr = 1'b0; dat_val = 32'd0;
    step(); step();
    chk("rst_cyc", {31'd0, iwbm_cyc_o}, 32'd0);
    chk("rst_addr", iwbm_addr_o, 32'h8000_0000);
    chk("rst_bubble", {31'd0, id_bubble_o}, 32'd1);
    chk("rst_inst", id_instruction_o, 32'h0000_0013);
    chk("rst_pc", id_pc_o, 32'd0);

    rstn_i = 1'b1;
    chk("rel_cyc0", {31'd0, iwbm_cyc_o}, 32'd0);
    step();
    chk("f0_cyc", {31'd0, iwbm_cyc_o}, 32'd1);
    chk("f0_addr", iwbm_addr_o, 32'h8000_0000);
    chk("f0_busy", {31'd0, if_busy_o}, 32'd0);
    step();
    chk("f1_addr", iwbm_addr_o, 32'h8000_0004);
    chk("id0_pc", id_pc_o, 32'h8000_0000);
    chk("id0_pc4", id_pc4_o, 32'h8000_0004);
    chk("id0_inst", id_instruction_o, 32'h8000_1000);
    chk("id0_bubble", {31'd0, id_bubble_o}, 32'd0);

    // Stall: ack for 0x8000_0004 while IF/ID disabled.
    ifid_enable_i = 1'b0; dat_ovr = 1'b1; dat_val = 32'hDEAD_BEEF;
    chk("hold_in_busy", {31'd0, if_busy_o}, 32'd0);
    step();
    chk("hold_cyc", {31'd0, iwbm_cyc_o}, 32'd0);
    chk("hold_idpc", id_pc_o, 32'h8000_0000);
    chk("hold_busy", {31'd0, if_busy_o}, 32'd0);
    step();
    chk("hold2_cyc", {31'd0, iwbm_cyc_o}, 32'd0);
    chk("hold2_inst", id_instruction_o, 32'h8000_1000);
    ifid_enable_i = 1'b1; dat_ovr = 1'b0;
    step();
    chk("drain_inst", id_instruction_o, 32'hDEAD_BEEF);
    chk("drain_pc", id_pc_o, 32'h8000_0004);
    chk("drain_addr", iwbm_addr_o, 32'h8000_0008);
    chk("drain_cyc", {31'd0, iwbm_cyc_o}, 32'd1);

    // Wait-state slave, branch in first wait cycle.
    ack_req = 1'b0; take_branch_i = 1'b1; pc_bj_target_i = 32'h8000_0100;
    step();
    take_branch_i = 1'b0;
    chk("disc_cyc", {31'd0, iwbm_cyc_o}, 32'd1);
    chk("disc_addr", iwbm_addr_o, 32'h8000_0008);
    chk("disc_bubble", {31'd0, id_bubble_o}, 32'd1);
    chk("disc_busy", {31'd0, if_busy_o}, 32'd1);
    step();
    chk("disc2_cyc", {31'd0, iwbm_cyc_o}, 32'd1);
    chk("disc2_addr", iwbm_addr_o, 32'h8000_0008);
    ack_req = 1'b1; dat_ovr = 1'b1; dat_val = 32'hBAD0_BAD0;
    step();
    dat_ovr = 1'b0;
    chk("br_addr", iwbm_addr_o, 32'h8000_0100);
    chk("br_bubble", {31'd0, id_bubble_o}, 32'd1);
    chk("br_inst", id_instruction_o, 32'h0000_0013);

    // xcall beats take_branch, both with an ack present.
    xcall_i = 1'b1; xcall_target_i = 32'h8000_0040;
    take_branch_i = 1'b1; pc_bj_target_i = 32'h8000_0100;
    step();
    xcall_i = 1'b0; take_branch_i = 1'b0;
    chk("prio_addr", iwbm_addr_o, 32'h8000_0040);
    chk("prio_bubble", {31'd0, id_bubble_o}, 32'd1);
    step();
    chk("x_idpc", id_pc_o, 32'h8000_0040);
    chk("x_inst", id_instruction_o, 32'h8000_1040);
    chk("x_addr", iwbm_addr_o, 32'h8000_0044);

    // Misaligned branch target gets word-aligned.
    take_branch_i = 1'b1; pc_bj_target_i = 32'h8000_0012;
    step();
    take_branch_i = 1'b0;
    chk("align_addr", iwbm_addr_o, 32'h8000_0010);

    // Bus error on 0x8000_0010.
    ack_req = 1'b0; err_req = 1'b1;
    chk("err_busy", {31'd0, if_busy_o}, 32'd0);
    step();
    err_req = 1'b0; ack_req = 1'b1;
    chk("flt_exc", {31'd0, id_if_exception_o}, 32'd1);
    chk("flt_cause", {28'd0, id_if_xcause_o}, 32'd1);
    chk("flt_pc", id_pc_o, 32'h8000_0010);
    chk("flt_pc4", id_pc4_o, 32'h8000_0014);
    chk("flt_inst", id_instruction_o, 32'h0000_0013);
    chk("flt_bubble", {31'd0, id_bubble_o}, 32'd0);
    chk("flt_cyc", {31'd0, iwbm_cyc_o}, 32'd0);
    take_branch_i = 1'b1; pc_bj_target_i = 32'h8000_0100;
    step();
    take_branch_i = 1'b0;
    chk("flt_br_cyc", {31'd0, iwbm_cyc_o}, 32'd0);
    chk("flt_br_addr", iwbm_addr_o, 32'h8000_0010);
    chk("flt_br_busy", {31'd0, if_busy_o}, 32'd1);
    xcall_i = 1'b1; xcall_target_i = 32'h8000_0004;
    step();
    xcall_i = 1'b0;
    chk("resume_addr", iwbm_addr_o, 32'h8000_0004);
    chk("resume_cyc", {31'd0, iwbm_cyc_o}, 32'd1);
    step();
    chk("resume_idpc", id_pc_o, 32'h8000_0004);
    chk("resume_inst", id_instruction_o, 32'h8000_1004);

    // Clear with ack: word consumed, pc advances, ID still sees a bubble.
    ifid_clear_i = 1'b1;
    step();
    ifid_clear_i = 1'b0;
    chk("clr_bubble", {31'd0, id_bubble_o}, 32'd1);
    chk("clr_idpc", id_pc_o, 32'd0);
    chk("clr_addr", iwbm_addr_o, 32'h8000_000C);

    // Reset in the middle of a pending transfer.
    ack_req = 1'b0;
    step();
    chk("pend_cyc", {31'd0, iwbm_cyc_o}, 32'd1);
    rstn_i = 1'b0; ack_req = 1'b1;
    step();
    chk("mrst_cyc", {31'd0, iwbm_cyc_o}, 32'd0);
    chk("mrst_addr", iwbm_addr_o, 32'h8000_0000);
    chk("mrst_bubble", {31'd0, id_bubble_o}, 32'd1);
    chk("mrst_inst", id_instruction_o, 32'h0000_0013);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
